line_arbiter: RTL

LINE_ARBITER -- requirements
Module: line_arbiter

---
 rtl/line_arb_pkg.sv | 12 +
 rtl/rr_picker.sv | 30 +++
 rtl/line_arbiter.sv | 107 ++++++++++
 3 files changed

// File: rtl/line_arb_pkg.sv
// Shared types and constants for the cache-line arbiter.
package line_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int PRIO_RR    = 0;
    localparam int PRIO_FIXED = 1;

endpackage

// File: rtl/rr_picker.sv
// Combinational winner selection: round-robin from ptr+1, or fixed lowest-index.
module rr_picker #(
    parameter int NUM_CH = 3,
    parameter int IDX_W  = 2
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    input  logic              mode,
    output logic [IDX_W-1:0]  idx,
    output logic              valid
);

    always_comb begin
        idx   = '0;
        valid = |req;
        if (mode) begin
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                if (req[i]) idx = IDX_W'(i);
            end
        end else begin
            // Walk offsets downward so the closest channel after ptr wins last.
            for (int k = NUM_CH; k >= 1; k--) begin
                int j;
                j = (int'(ptr) + k) % NUM_CH;
                if (req[j]) idx = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/line_arbiter.sv
// Arbitrates NUM_CH cache-line requestors onto one cacheline adaptor port.
// Optional LINE_ARBITER_PERF_EN adds per-channel completion counters (grant_count).
module line_arbiter
    import line_arb_pkg::*;
#(
    parameter int NUM_CH    = 3,
    parameter int LINE_W    = 256,
    parameter int ADDR_W    = 32,
    parameter int PRIO_MODE = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_CH-1:0]              ch_read,
    input  logic [NUM_CH-1:0]              ch_write,
    input  logic [NUM_CH-1:0][ADDR_W-1:0]  ch_address,
    input  logic [NUM_CH-1:0][LINE_W-1:0]  ch_wdata,
    output logic [NUM_CH-1:0]              ch_resp,
    output logic [LINE_W-1:0]              ch_rdata,
    output logic                           mem_read,
    output logic                           mem_write,
    output logic [ADDR_W-1:0]              mem_address,
    output logic [LINE_W-1:0]              mem_wdata,
    input  logic                           mem_resp,
    input  logic [LINE_W-1:0]              mem_rdata
`ifdef LINE_ARBITER_PERF_EN
    ,
    output logic [NUM_CH-1:0][31:0]        grant_count
`endif
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    state_t             state;
    logic [IDX_W-1:0]   gnt;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   win;
    logic               win_valid;
    logic [NUM_CH-1:0]  req;

    assign req = ch_read | ch_write;

    rr_picker #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_pick (
        .req   (req),
        .ptr   (ptr),
        .mode  (PRIO_MODE == PRIO_FIXED),
        .idx   (win),
        .valid (win_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            gnt         <= '0;
            ptr         <= IDX_W'(NUM_CH - 1);
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_valid) begin
                        state       <= BUSY;
                        gnt         <= win;
                        ptr         <= win;
                        // A simultaneous read+write is served as a write.
                        mem_write   <= ch_write[win];
                        mem_read    <= !ch_write[win];
                        mem_address <= ch_address[win];
                        mem_wdata   <= ch_wdata[win];
                    end
                end
                BUSY: begin
                    if (mem_resp) begin
                        state     <= IDLE;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        ch_resp = '0;
        if (state == BUSY && mem_resp) ch_resp[gnt] = 1'b1;
    end

    assign ch_rdata = mem_rdata;

`ifdef LINE_ARBITER_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_count <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_resp[i]) grant_count[i] <= grant_count[i] + 32'd1;
            end
        end
    end
`endif

endmodule
